// File: rtl/inst_buffer.sv
// ---------------------------------------------------------------------------
// inst_buffer
//
// Purpose:
//   Circular instruction buffer between fetch and dispatch. Fetch pushes up
//   to `N packets per cycle. Dispatch pops up to `N per cycle. Slot 0 is the
//   oldest packet on both sides.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset (drops all entries)
//   flush        in   branch-stack restore; drops all entries on this edge
//   enq_packets  in   `N fetch packets, slot 0 oldest
//   enq_count    in   number of valid enq_packets, counted from slot 0
//   spots        out  free entries offered to fetch, min(DEPTH-count, `N)
//   deq_request  in   number of packets dispatch can take this cycle
//   deq_packets  out  oldest entries, slot 0 = head; unused slots are zero
//   deq_valid    out  number of valid deq_packets, counted from slot 0
//   perf_full_cycles    out  (INST_BUFFER_PERF_EN only) saturating count of
//                            cycles spent full
//   perf_max_occupancy  out  (INST_BUFFER_PERF_EN only) high-water mark of
//                            the entry count
//
// Configuration:
//   Define INST_BUFFER_PERF_EN to add the two performance-counter outputs.
//   With the macro undefined, neither the ports nor the counters exist.
//   `N and `NUM_SCALAR_BITS fall back to 3 and $clog2(`N+1) when the
//   surrounding build does not provide them.
// ---------------------------------------------------------------------------

`ifndef N
`define N 3
`endif

`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N+1)
`endif

package inst_buffer_pkg;

  localparam int IB_N  = `N;
  localparam int IB_SB = `NUM_SCALAR_BITS;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic        predict_taken;
    logic [7:0]  bp_packet;
    logic [31:0] predicted_PC;
    logic        is_jump;
  } FETCH_PACKET;

endpackage

module inst_buffer
  import inst_buffer_pkg::*;
#(
  // Entry count. Must be a power of two and at least `N.
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  FETCH_PACKET [`N-1:0]         enq_packets,
  input  logic [`NUM_SCALAR_BITS-1:0]  enq_count,
  output logic [`NUM_SCALAR_BITS-1:0]  spots,
  input  logic [`NUM_SCALAR_BITS-1:0]  deq_request,
  output FETCH_PACKET [`N-1:0]         deq_packets,
  output logic [`NUM_SCALAR_BITS-1:0]  deq_valid
`ifdef INST_BUFFER_PERF_EN
  ,
  output logic [31:0]                  perf_full_cycles,
  output logic [$clog2(DEPTH):0]       perf_max_occupancy
`endif
);

  localparam int N_L   = `N;
  localparam int SB    = `NUM_SCALAR_BITS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage. Never reset: reads are masked by deq_valid, so stale contents
  // can never reach deq_packets.
  FETCH_PACKET mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] free_w;
  logic [SB-1:0]    accepted_w;
  logic [SB-1:0]    occ_w;
  logic [SB-1:0]    deq_valid_w;

  // -------------------------------------------------------------------------
  // Fetch side. spots depends only on the registered count. It ignores
  // deq_request and flush so that fetch sees no combinational path back
  // through dispatch.
  // -------------------------------------------------------------------------
  always_comb begin
    free_w = CNT_W'(DEPTH) - count_q;
    if (free_w > CNT_W'(N_L)) begin
      spots = SB'(N_L);
    end else begin
      spots = SB'(free_w);
    end
  end

  // Packets beyond spots are dropped, never written over live entries.
  // During flush, nothing is accepted or released.
  always_comb begin
    accepted_w = (enq_count > spots) ? spots : enq_count;
    if (flush) begin
      accepted_w = '0;
    end

    occ_w = (count_q > CNT_W'(N_L)) ? SB'(N_L) : SB'(count_q);
    deq_valid_w = (deq_request > occ_w) ? occ_w : deq_request;
    if (flush) begin
      deq_valid_w = '0;
    end
  end

  assign deq_valid = deq_valid_w;

  // -------------------------------------------------------------------------
  // Next-state pointers and count. A simultaneous push and pop both apply.
  // Pointers wrap naturally because DEPTH is a power of two.
  // -------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q + PTR_W'(deq_valid_w);
    tail_d  = tail_q + PTR_W'(accepted_w);
    count_d = count_q + CNT_W'(accepted_w) - CNT_W'(deq_valid_w);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the accepted packets at tail..tail+accepted-1, modulo DEPTH.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_L; i++) begin
      if (!reset && (SB'(i) < accepted_w)) begin
        mem_q[tail_q + PTR_W'(i)] <= enq_packets[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Dispatch side. Reads come from registered state only, so a packet
  // written at an edge shows up no earlier than the next cycle.
  // Slots at or beyond deq_valid are forced to zero.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_L; gi++) begin : g_rd
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx          = head_q + PTR_W'(gi);
      assign deq_packets[gi] = (SB'(gi) < deq_valid_w) ? mem_q[rd_idx] : '0;
    end
  endgenerate

`ifdef INST_BUFFER_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters. Reset clears them. Flush leaves them alone, so
  // they keep their history across branch recoveries.
  // -------------------------------------------------------------------------
  logic [31:0]      full_cycles_q, full_cycles_d;
  logic [CNT_W-1:0] max_occ_q, max_occ_d;

  always_comb begin
    full_cycles_d = full_cycles_q;
    if ((count_q == CNT_W'(DEPTH)) && (full_cycles_q != 32'hFFFF_FFFF)) begin
      full_cycles_d = full_cycles_q + 32'd1;
    end
    max_occ_d = (count_q > max_occ_q) ? count_q : max_occ_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_cycles_q <= '0;
      max_occ_q     <= '0;
    end else begin
      full_cycles_q <= full_cycles_d;
      max_occ_q     <= max_occ_d;
    end
  end

  assign perf_full_cycles   = full_cycles_q;
  assign perf_max_occupancy = max_occ_q;
`endif

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; a power of two and at least `N.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  branch-stack restore; discard all entries.
REQ-005 SHALL have port enq_packets  input  FETCH_PACKET[`N]  fetched instructions, slot 0 oldest.
REQ-006 SHALL have port enq_count  input  `NUM_SCALAR_BITS  number of valid enq_packets, counted from slot 0.
REQ-007 SHALL have port spots  output  `NUM_SCALAR_BITS  free entries offered to fetch, min(DEPTH-count, `N).
REQ-008 SHALL have port deq_request  input  `NUM_SCALAR_BITS  number of instructions dispatch can accept this cycle.
REQ-009 SHALL have port deq_packets  output  FETCH_PACKET[`N]  oldest entries, slot 0 = head.
REQ-010 SHALL have port deq_valid  output  `NUM_SCALAR_BITS  number of valid deq_packets, counted from slot 0.

Function
REQ-011 SHALL store entries in a circular array with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, and a count register of $clog2(DEPTH)+1 bits.
REQ-012 SHALL drive spots combinationally from the registered count only, with no dependence on same-cycle deq_request or flush, so that fetch sees no combinational loop.
REQ-013 SHALL write accepted = min(enq_count, spots) packets at tail..tail+accepted-1 on the clock edge; enq_count above spots SHALL be clamped, never overwriting valid entries.
REQ-014 SHALL drive deq_valid = min(count, deq_request, `N) and deq_packets[i] = entry[head+i] for i < deq_valid, with the remaining slots all-zero; this output is combinational from registered state.
REQ-015 SHALL advance head by deq_valid on the clock edge; a packet enqueued at edge k SHALL appear on deq_packets no earlier than the cycle after edge k, with no same-cycle bypass.
REQ-016 SHALL apply simultaneous enqueue and dequeue in the same edge: count_next = count + accepted - deq_valid.
REQ-017 SHALL, when the buffer is full (count == DEPTH), drive spots = 0 and still dequeue normally.
REQ-018 SHALL, when the buffer is empty, drive deq_valid = 0 with all deq_packets zero, regardless of deq_request.
REQ-019 SHALL, while flush is high, drive deq_valid = 0 and ignore enqueue and dequeue; on that edge it SHALL set head = tail = count = 0.
REQ-020 SHALL preserve FETCH_PACKET fields (inst, PC, predict_taken, bp_packet, predicted_PC, is_jump) bit-exactly and in program order.

Reset
REQ-021 SHALL, on reset, set head = tail = count = 0, so spots = `N, deq_valid = 0 and deq_packets = 0 from the next cycle.
REQ-022 SHALL give reset priority over flush, enqueue and dequeue; a reset mid-operation SHALL discard every stored entry.
REQ-023 SHALL not require the storage array to be cleared on reset; stale data SHALL never be visible, because of REQ-014.

Configuration
REQ-024 SHALL, when INST_BUFFER_PERF_EN is defined, add outputs perf_full_cycles (32 bits, increments each cycle count == DEPTH, saturating) and perf_max_occupancy ($clog2(DEPTH)+1 bits, high-water mark of count).
REQ-025 SHALL clear both perf outputs on reset but not on flush.
REQ-026 SHALL, when INST_BUFFER_PERF_EN is undefined, have neither perf port nor perf logic, with all other behaviour identical.

Verification (N=3, DEPTH=8)
REQ-027 SHALL cover: reset, then enq_count=3 (PCs 0x0,0x4,0x8) with deq_request=0 -> next cycle spots=3, deq_valid=0; after three such bursts count=8, spots=0.
REQ-028 SHALL cover: count=7, enq_count=3 -> spots was 1, only PC of slot 0 stored, count=8, no overwrite.
REQ-029 SHALL cover: count=2, deq_request=3 with enq_count=3 in the same cycle -> deq_valid=2 that cycle; next cycle count=3 and deq_packets hold the 3 new PCs in order.
REQ-030 SHALL cover: head=6, count=2, enqueue 3 -> tail wraps to 3; the following dequeues return PCs in order across the wrap.
REQ-031 SHALL cover: count=5 with flush=1 and enq_count=3, deq_request=3 -> deq_valid=0 that cycle; next cycle count=0, spots=3.
REQ-032 SHALL cover: with INST_BUFFER_PERF_EN, hold full for 4 cycles then flush -> perf_full_cycles=4, perf_max_occupancy=8, both retained after the flush.
